// File: rtl/sort_ctrl_pkg.sv
// Shared definitions for the in-place selection-sort controller: index widths,
// terminal index values and the controller state encoding.
package sort_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] LAST_IDX = 5'd31;
  localparam logic [ADDR_W-1:0] LAST_I   = 5'd30;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LD_I   = 4'd1,
    CAP_I  = 4'd2,
    LD_J   = 4'd3,
    CMP_J  = 4'd4,
    SWAP_A = 4'd5,
    SWAP_B = 4'd6,
    NEXT_I = 4'd7,
    DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/sort_ctrl_if.sv
// Control and memory-port bundle between the sort controller and its host/memory.
interface sort_ctrl_if #(
  parameter int DATA_W = 8
);
  import sort_ctrl_pkg::*;

  // start is a single-cycle request sampled only in IDLE; done pulses for one
  // cycle at completion. mem_rdata returns the word addressed by mem_adr in the
  // cycle after mem_rd is high; mem_wr commits mem_wdata at mem_adr that cycle.
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  start, mem_rdata,
    output busy, done, mem_rd, mem_wr, mem_adr, mem_wdata
  );

  modport master (
    output start, mem_rdata,
    input  busy, done, mem_rd, mem_wr, mem_adr, mem_wdata
  );

endinterface

// File: rtl/sort_idx_cnt.sv
// Loadable 5-bit index counter with a terminal-count flag; saturates at TC_VAL
// so an index can never wrap past the end of the array.
module sort_idx_cnt
  import sort_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TC_VAL = LAST_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/sort_ctrl.sv
// Selection-sort controller sorting a 32-entry external memory in place.
// Define SORT_CTRL_DESC_EN for a descending sort; the default is ascending.
module sort_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  sort_ctrl_if.slave  bus,
  output state_t      dbg_state
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [ADDR_W-1:0] min_idx_q, min_idx_d;

  logic              i_load, i_inc, i_tc;
  logic [ADDR_W-1:0] i_val, i_cnt;
  logic              j_load, j_inc, j_tc;
  logic [ADDR_W-1:0] j_val, j_cnt;

  logic              busy, done, mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              better;

  sort_idx_cnt #(.TC_VAL(LAST_I)) u_i_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (i_load),
    .load_val (i_val),
    .inc      (i_inc),
    .cnt      (i_cnt),
    .tc       (i_tc)
  );

  sort_idx_cnt #(.TC_VAL(LAST_IDX)) u_j_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (j_load),
    .load_val (j_val),
    .inc      (j_inc),
    .cnt      (j_cnt),
    .tc       (j_tc)
  );

  // Strict compare: ties never displace the current candidate.
`ifdef SORT_CTRL_DESC_EN
  assign better = (bus.mem_rdata > min_q);
`else
  assign better = (bus.mem_rdata < min_q);
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    min_d     = min_q;
    min_idx_d = min_idx_q;
    i_load    = 1'b0;
    i_val     = '0;
    i_inc     = 1'b0;
    j_load    = 1'b0;
    j_val     = '0;
    j_inc     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          i_load  = 1'b1;
          i_val   = '0;
          state_d = LD_I;
        end
      end
      LD_I: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        mem_adr = i_cnt;
        state_d = CAP_I;
      end
      CAP_I: begin
        busy      = 1'b1;
        cur_d     = bus.mem_rdata;
        min_d     = bus.mem_rdata;
        min_idx_d = i_cnt;
        j_load    = 1'b1;
        j_val     = i_cnt + 5'd1;
        state_d   = LD_J;
      end
      LD_J: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        mem_adr = j_cnt;
        state_d = CMP_J;
      end
      CMP_J: begin
        busy = 1'b1;
        if (better) begin
          min_d     = bus.mem_rdata;
          min_idx_d = j_cnt;
        end
        if (j_tc) begin
          state_d = SWAP_A;
        end else begin
          j_inc   = 1'b1;
          state_d = LD_J;
        end
      end
      SWAP_A: begin
        busy = 1'b1;
        // The old value at i moves to the minimum's slot first.
        if (min_idx_q != i_cnt) begin
          mem_wr    = 1'b1;
          mem_adr   = min_idx_q;
          mem_wdata = cur_q;
          state_d   = SWAP_B;
        end else begin
          state_d = NEXT_I;
        end
      end
      SWAP_B: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_adr   = i_cnt;
        mem_wdata = min_q;
        state_d   = NEXT_I;
      end
      NEXT_I: begin
        busy = 1'b1;
        if (i_tc) begin
          state_d = DONE;
        end else begin
          i_inc   = 1'b1;
          state_d = LD_I;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      min_q     <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
    end
  end

  // Outputs decode only from flops with async reset, so they clear with rst.
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_adr   = mem_adr;
  assign bus.mem_wdata = mem_wdata;
  assign dbg_state     = state_q;

endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the memory data word and of the compare path.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle request to sort the 32-entry memory in place.
REQ-005 The block SHALL have port busy  output  1  high while a sort is in progress.
REQ-006 The block SHALL have port done  output  1  one-cycle pulse when the sort completes.
REQ-007 The block SHALL have port mem_rd  output  1  memory read strobe.
REQ-008 The block SHALL have port mem_wr  output  1  memory write strobe.
REQ-009 The block SHALL have port mem_adr  output  5  memory address.
REQ-010 The block SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-011 The block SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd (registered read, 1-cycle latency).

Function
REQ-012 The block SHALL implement an in-place selection sort over addresses 0..31, ascending by default, with unsigned compares.
REQ-013 The FSM SHALL use states IDLE, LD_I, CAP_I, LD_J, CMP_J, SWAP_A, SWAP_B, NEXT_I and DONE.
REQ-014 IDLE: start=1 -> i=0, go LD_I; otherwise stay in IDLE.
REQ-015 LD_I: mem_rd=1, mem_adr=i -> CAP_I.
REQ-016 CAP_I: cur<=mem_rdata, min<=mem_rdata, min_idx<=i, j<=i+1 -> LD_J.
REQ-017 LD_J: mem_rd=1, mem_adr=j -> CMP_J.
REQ-018 CMP_J: if mem_rdata<min (strict), then min<=mem_rdata and min_idx<=j; if j==31 -> SWAP_A, else j<=j+1 -> LD_J.
REQ-019 Equal values SHALL NOT update min_idx, so the first occurrence is kept.
REQ-020 SWAP_A: if min_idx!=i, then mem_wr=1, mem_adr=min_idx, mem_wdata=cur -> SWAP_B; otherwise issue no write -> NEXT_I.
REQ-021 SWAP_B: mem_wr=1, mem_adr=i, mem_wdata=min -> NEXT_I.
REQ-022 NEXT_I: if i==30 -> DONE, else i<=i+1 -> LD_I.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 busy SHALL be high in every state except IDLE and DONE.
REQ-025 With S swaps performed, busy SHALL be high for exactly 1116+S cycles.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 start SHALL be honoured in the cycle after DONE.
REQ-028 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-029 mem_adr SHALL be 0 and mem_wdata SHALL be 0 whenever no strobe is active.
REQ-030 Index counters SHALL NOT wrap: i spans 0..30 and j spans i+1..31.

Reset
REQ-031 On rst low, the FSM SHALL go to IDLE immediately, including mid-sort, and busy, done, mem_rd, mem_wr, mem_adr and mem_wdata SHALL be 0 asynchronously.
REQ-032 On rst low, i, j, min_idx, cur and min SHALL be 0.
REQ-033 Memory contents left by an aborted sort SHALL be unspecified; no completion pulse SHALL occur.

Configuration
REQ-034 With SORT_CTRL_DESC_EN defined, CMP_J SHALL use strict mem_rdata>min, producing a descending sort; all timing is unchanged.
REQ-035 Without SORT_CTRL_DESC_EN, the block SHALL sort ascending as per REQ-018.

Structure
REQ-036 The shared package sort_ctrl_pkg SHALL hold the state enum, ADDR_W=5, LAST_IDX=31 and LAST_I=30.
REQ-037 The i and j indices SHALL each be one instance of sub-module sort_idx_cnt (5-bit, with load, increment and terminal-count flag).

Verification
REQ-038 The bench SHALL load memory 0..31 ascending, pulse start, and check: zero mem_wr cycles, busy high 1116 cycles, done one cycle, memory unchanged.
REQ-039 The bench SHALL load memory 31..0 descending, pulse start, and check: S=16 swaps (32 write cycles), busy high 1132 cycles, final memory 0..31.
REQ-040 The bench SHALL load all entries with 8'hAA, pulse start, and check: zero writes and memory unchanged.
REQ-041 The bench SHALL load random data, pulse start, re-pulse start mid-sort, and check: the second start is ignored, one done pulse, and the result is a sorted permutation of the input.
REQ-042 The bench SHALL assert rst low at busy cycle 500, then release it, and check: all outputs 0 in the same cycle, FSM in IDLE, and a fresh start then sorts correctly.
REQ-043 The bench SHALL build with SORT_CTRL_DESC_EN, load memory 0..31, pulse start, and check: final memory 31..0 and 16 swaps.
